// File: rtl/spkr_pkg.sv
// Shared types and gain arithmetic for the speaker sample scheduler.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package spkr_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t lft;
        sample_t rght;
    } stereo_t;

    typedef logic [1:0] sched_state_e;
    localparam sched_state_e FILL  = 2'd0;
    localparam sched_state_e RUN   = 2'd1;
    localparam sched_state_e UNDER = 2'd2;

    // Gain is unsigned; full scale 2**shift reproduces the sample exactly.
    function automatic sample_t scale(input sample_t smp, input logic [15:0] gain, input int shift);
        logic signed [31:0] prod;
        prod = 32'(smp) * $signed({16'd0, gain});
        prod = prod >>> shift;
        return prod[15:0];
    endfunction

endpackage

// File: rtl/spkr_sched_if.sv
// Bundle between the EQ engine / speaker driver side and the scheduler.
// Latency: none (wiring only).
// Backpressure: in_rdy from the scheduler throttles in_vld; vld has none.
interface spkr_sched_if
    import spkr_pkg::*;
#(
    parameter int DEPTH = 16
);
    logic                   in_vld;
    logic                   in_rdy;
    sample_t                lft_in;
    sample_t                rght_in;
    logic                   mute;
    logic                   vld;
    sample_t                lft_chnnl;
    sample_t                rght_chnnl;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic [7:0]             underrun_cnt;

    modport master (
        output in_vld, lft_in, rght_in, mute,
        input  in_rdy, vld, lft_chnnl, rght_chnnl, fifo_cnt, underrun_cnt
    );

    modport slave (
        input  in_vld, lft_in, rght_in, mute,
        output in_rdy, vld, lft_chnnl, rght_chnnl, fifo_cnt, underrun_cnt
    );
endinterface

// File: rtl/stereo_fifo.sv
// First-word-fall-through FIFO of stereo pairs.
// Latency: pushed word visible on rd_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module stereo_fifo
    import spkr_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  stereo_t                wr_dat,
    input  logic                   pop,
    output stereo_t                rd_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    stereo_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/spkr_sched.sv
// Buffers bursty stereo samples and releases one gain-ramped pair every SAMPLE_PERIOD clocks.
// Latency: vld and the popped pair appear 1 clk after each tick; zero pair when not running.
// Backpressure: in_rdy = !full; the speaker driver side takes every strobe.
module spkr_sched
    import spkr_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 1024,
    parameter int DEPTH         = 16,
    parameter int PREFILL       = 8,
    parameter int GAIN_SHIFT    = 6
) (
    input logic        clk,
    input logic        rst_n,
    spkr_sched_if.slave bus
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = GAIN_SHIFT + 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] PREFILL_CNT = CW'(PREFILL);
    localparam logic [GW-1:0] GAIN_FULL   = GW'(1 << GAIN_SHIFT);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    sched_state_e  state;
    logic [GW-1:0] gain;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    stereo_t       fifo_dat;
    logic [CW-1:0] fifo_cnt;
    logic          vld_q;
    sample_t       lft_q;
    sample_t       rght_q;
    logic [7:0]    underrun_q;

    assign tick = (tick_cnt == TICK_LAST);
    assign push = bus.in_vld && !full;
    assign pop  = tick && (state == RUN) && !empty;

    assign bus.in_rdy       = !full;
    assign bus.fifo_cnt     = fifo_cnt;
    assign bus.vld          = vld_q;
    assign bus.lft_chnnl    = lft_q;
    assign bus.rght_chnnl   = rght_q;
    assign bus.underrun_cnt = underrun_q;

    stereo_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wr_dat ('{lft: bus.lft_in, rght: bus.rght_in}),
        .pop    (pop),
        .rd_dat (fifo_dat),
        .full   (full),
        .empty  (empty),
        .cnt    (fifo_cnt)
    );

    // The sample clock never pauses, whatever the FIFO or mute state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            unique case (state)
                RUN:     if (tick && empty) state <= UNDER;
                default: if (fifo_cnt >= PREFILL_CNT) state <= RUN;
            endcase
        end
    end

    // Scaling uses the gain held before this tick's ramp step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            lft_q      <= '0;
            rght_q     <= '0;
            gain       <= '0;
            underrun_q <= '0;
        end else begin
            vld_q <= tick;
            if (tick) begin
                if (pop) begin
                    lft_q  <= scale(fifo_dat.lft,  16'(gain), GAIN_SHIFT);
                    rght_q <= scale(fifo_dat.rght, 16'(gain), GAIN_SHIFT);
                end else begin
                    lft_q  <= '0;
                    rght_q <= '0;
                end
                if (bus.mute && gain != '0)
                    gain <= gain - 1'b1;
                else if (!bus.mute && gain != GAIN_FULL)
                    gain <= gain + 1'b1;
                if (state == RUN && empty && underrun_q != 8'hFF)
                    underrun_q <= underrun_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spkr_sched.sv
// Directed bench for spkr_sched with a short sample period.
module tb_spkr_sched;
    import spkr_pkg::*;

    localparam int SP = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spkr_sched_if #(.DEPTH(16)) bus();

    spkr_sched #(
        .SAMPLE_PERIOD (SP),
        .DEPTH         (16),
        .PREFILL       (8),
        .GAIN_SHIFT    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int l, input int r);
        chk({tag, "_lft"},  16'(bus.lft_chnnl),  16'(l));
        chk({tag, "_rght"}, 16'(bus.rght_chnnl), 16'(r));
    endtask

    task automatic wait_vld(input string tag, output int waited);
        waited = 0;
        for (int i = 1; i <= SP + 4; i++) begin
            @(negedge clk);
            if (bus.vld) begin
                waited = i;
                break;
            end
        end
        if (waited == 0) chk({tag, "_timeout"}, 16'(bus.vld), 16'(1));
    endtask

    task automatic push(input int l, input int r);
        bus.in_vld  = 1'b1;
        bus.lft_in  = 16'(l);
        bus.rght_in = 16'(r);
        @(negedge clk);
        bus.in_vld  = 1'b0;
    endtask

    initial begin
        int      w;
        int      g;
        int      seq [5];
        sample_t prev;

        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.lft_in  = '0;
        bus.rght_in = '0;
        bus.mute    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_rdy",   16'(bus.in_rdy),       16'(1));
        chk("rst_vld",      16'(bus.vld),          16'(0));
        chk_out("rst", 0, 0);
        chk("rst_fifo_cnt", 16'(bus.fifo_cnt),     16'(0));
        chk("rst_underrun", 16'(bus.underrun_cnt), 16'(0));
        chk("rst_state",    16'(dut.state),        16'(FILL));
        rst_n = 1'b1;

        // Idle: strobe every period, zero pairs, stays in FILL
        for (int k = 0; k < 3; k++) begin
            wait_vld("t1", w);
            chk($sformatf("t1_period_%0d", k), 16'(w), 16'((k == 0) ? SP : SP - 1));
            chk_out($sformatf("t1_out_%0d", k), 0, 0);
            chk("t1_state", 16'(dut.state), 16'(FILL));
            chk("t1_underrun", 16'(bus.underrun_cnt), 16'(0));
            @(negedge clk);
            chk("t1_vld_pulse", 16'(bus.vld), 16'(0));
        end

        // Fade-in from gain 0 after a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(4096, -4096);
        chk("t2_cnt8", 16'(bus.fifo_cnt), 16'(8));
        @(negedge clk);
        chk("t2_state_run", 16'(dut.state), 16'(RUN));
        for (int k = 0; k < 70; k++) begin
            wait_vld("t2", w);
            g = (k >= 64) ? 64 : k;
            chk_out($sformatf("t2_%0d", k), 4096 * g / 64, -4096 * g / 64);
            push(4096, -4096);
        end

        // Underrun: drain the 8 buffered pairs, then zero pair and UNDER
        for (int k = 0; k < 8; k++) begin
            wait_vld("t3", w);
            chk_out($sformatf("t3_data_%0d", k), 4096, -4096);
        end
        wait_vld("t3u", w);
        chk_out("t3_zero", 0, 0);
        chk("t3_underrun1", 16'(bus.underrun_cnt), 16'(1));
        chk("t3_state_under", 16'(dut.state), 16'(UNDER));
        for (int k = 0; k < 2; k++) begin
            wait_vld("t3h", w);
            chk_out("t3_hold", 0, 0);
            chk("t3_underrun_hold", 16'(bus.underrun_cnt), 16'(1));
            chk("t3_state_hold", 16'(dut.state), 16'(UNDER));
        end
        for (int i = 1; i <= 8; i++) push(i * 256, -i * 256);
        @(negedge clk);
        chk("t3_state_rerun", 16'(dut.state), 16'(RUN));
        for (int i = 1; i <= 8; i++) begin
            wait_vld("t3r", w);
            chk_out($sformatf("t3_order_%0d", i), i * 256, -i * 256);
        end

        // Fill to full with in_vld held; 17th pair must be rejected
        bus.in_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.lft_in  = 16'(100 + i);
            bus.rght_in = 16'(-(100 + i));
            @(negedge clk);
        end
        bus.lft_in  = 16'(999);
        bus.rght_in = 16'(-999);
        chk("t4_cnt16", 16'(bus.fifo_cnt), 16'(16));
        chk("t4_rdy_low", 16'(bus.in_rdy), 16'(0));
        repeat (3) @(negedge clk);
        chk("t4_cnt16_hold", 16'(bus.fifo_cnt), 16'(16));
        wait_vld("t4", w);
        bus.in_vld = 1'b0;
        chk_out("t4_first", 100, -100);
        chk("t4_cnt15", 16'(bus.fifo_cnt), 16'(15));
        chk("t4_rdy_back", 16'(bus.in_rdy), 16'(1));

        // Drain to 5, then push exactly on the pop tick
        for (int i = 101; i <= 110; i++) begin
            wait_vld("t5", w);
            chk_out($sformatf("t5_drain_%0d", i), i, -i);
        end
        chk("t5_cnt5", 16'(bus.fifo_cnt), 16'(5));
        for (int j = 0; j < 3; j++) begin
            repeat (SP - 1) @(negedge clk);
            bus.in_vld  = 1'b1;
            bus.lft_in  = 16'(201 + j);
            bus.rght_in = 16'(-(201 + j));
            @(negedge clk);
            bus.in_vld  = 1'b0;
            chk("t5_pp_vld", 16'(bus.vld), 16'(1));
            chk("t5_pp_cnt", 16'(bus.fifo_cnt), 16'(5));
            chk_out($sformatf("t5_pp_%0d", j), 111 + j, -(111 + j));
        end
        seq = '{114, 115, 201, 202, 203};
        for (int k = 0; k < 5; k++) begin
            wait_vld("t5s", w);
            chk_out($sformatf("t5_seq_%0d", k), seq[k], -seq[k]);
        end
        wait_vld("t5u", w);
        chk_out("t5_zero", 0, 0);
        chk("t5_underrun2", 16'(bus.underrun_cnt), 16'(2));
        chk("t5_state_under", 16'(dut.state), 16'(UNDER));

        // Mute ramp-down from full gain with full-scale input
        for (int i = 0; i < 8; i++) push(32767, -32767);
        wait_vld("t6", w);
        chk_out("t6_full", 32767, -32767);
        push(32767, -32767);
        bus.mute = 1'b1;
        prev = 16'sh7fff;
        for (int k = 0; k < 66; k++) begin
            wait_vld("t6m", w);
            g = (k >= 64) ? 0 : 64 - k;
            chk_out($sformatf("t6_mute_%0d", k), (32767 * g) >>> 6, (-32767 * g) >>> 6);
            if (k > 0)
                chk("t6_mono", 16'(bus.lft_chnnl < prev || bus.lft_chnnl == 0), 16'(1));
            prev = bus.lft_chnnl;
            push(32767, -32767);
        end

        // Unmute, then reset in the middle of the ramp and of a period
        bus.mute = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_vld("t6r", w);
            chk_out($sformatf("t6_up_%0d", k), (32767 * k) >>> 6, (-32767 * k) >>> 6);
            push(32767, -32767);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst", 0, 0);
        chk("t6_rst_cnt", 16'(bus.fifo_cnt), 16'(0));
        chk("t6_rst_underrun", 16'(bus.underrun_cnt), 16'(0));
        chk("t6_rst_rdy", 16'(bus.in_rdy), 16'(1));
        chk("t6_rst_vld", 16'(bus.vld), 16'(0));
        chk("t6_rst_state", 16'(dut.state), 16'(FILL));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_vld("t6p", w);
        chk("t6_post_rst_period", 16'(w), 16'(SP));
        chk_out("t6_post_rst", 0, 0);
        chk("t6_post_state", 16'(dut.state), 16'(FILL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
